// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - result-select and load-type codes shared by the MEM/WB stage
package mem_wb_stage_pkg;

  // Writeback mux select codes; RESULT_RSV never writes the register file
  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_LOAD = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSV  = 2'b11
  } result_src_e;

  // Load funct3 codes; 011, 110 and 111 are unsupported
  typedef enum logic [2:0] {
    LOAD_LB  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LW  = 3'b010,
    LOAD_LBU = 3'b100,
    LOAD_LHU = 3'b101
  } load_funct3_e;

  function automatic logic is_load(input logic [1:0] src);
    return src == RESULT_LOAD;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - combinational load-data alignment and sign/zero extension
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half, extend it, and fall back to the raw word on any error
  always_comb begin
    data = rdata;
    err  = 1'b0;
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LOAD_LB:  data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {{(WIDTH-8){1'b0}}, byte_sel};
      LOAD_LH: begin
        if (offset[0]) err = 1'b1;
        else           data = {{(WIDTH-16){half_sel[15]}}, half_sel};
      end
      LOAD_LHU: begin
        if (offset[0]) err = 1'b1;
        else           data = {{(WIDTH-16){1'b0}}, half_sel};
      end
      LOAD_LW: begin
        if (offset != 2'd0) err = 1'b1;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB pipeline register with stall/flush; RETIRE_COUNTER_EN adds w_retired
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  m_valid,
  input  logic [WIDTH-1:0]      m_alu_result,
  input  logic [WIDTH-1:0]      m_rdata,
  input  logic [WIDTH-1:0]      m_pc_plus4,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic                  m_reg_write,
  input  logic [1:0]            m_result_src,
  input  logic [2:0]            m_funct3,
  output logic [WIDTH-1:0]      w_input0,
  output logic [WIDTH-1:0]      w_input1,
  output logic [WIDTH-1:0]      w_input2,
  output logic [1:0]            w_s,
  output logic [REG_ADDR_W-1:0] w_rd,
  output logic                  w_reg_write,
  output logic                  w_valid,
  output logic                  w_load_err
`ifdef RETIRE_COUNTER_EN
  ,
  output logic [31:0]           w_retired
`endif
);

  logic [WIDTH-1:0]      alu_q, alu_d;
  logic [WIDTH-1:0]      ldata_q, ldata_d;
  logic [WIDTH-1:0]      pc4_q, pc4_d;
  logic [1:0]            s_q, s_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  reg_write_q, reg_write_d;
  logic                  valid_q, valid_d;
  logic                  load_err_q, load_err_d;
  logic [WIDTH-1:0]      aligned;
  logic                  align_err;
  logic                  capture;

  mem_wb_stage_load_align #(.WIDTH(WIDTH)) u_load_align (
    .rdata  (m_rdata),
    .offset (m_alu_result[1:0]),
    .funct3 (m_funct3),
    .data   (aligned),
    .err    (align_err)
  );

  assign capture = !flush && !stall;

  // Next state: flush kills the control bits (data held), stall holds everything, else capture
  always_comb begin
    alu_d       = alu_q;
    ldata_d     = ldata_q;
    pc4_d       = pc4_q;
    s_d         = s_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    load_err_d  = load_err_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      load_err_d  = 1'b0;
    end else if (!stall) begin
      alu_d       = m_alu_result;
      ldata_d     = aligned;
      pc4_d       = m_pc_plus4;
      s_d         = m_result_src;
      rd_d        = m_rd;
      valid_d     = m_valid;
      reg_write_d = m_valid && m_reg_write && (m_rd != '0) && (m_result_src != RESULT_RSV);
      load_err_d  = m_valid && is_load(m_result_src) && align_err;
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q       <= '0;
      ldata_q     <= '0;
      pc4_q       <= '0;
      s_q         <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      alu_q       <= alu_d;
      ldata_q     <= ldata_d;
      pc4_q       <= pc4_d;
      s_q         <= s_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      load_err_q  <= load_err_d;
    end
  end

  assign w_input0    = alu_q;
  assign w_input1    = ldata_q;
  assign w_input2    = pc4_q;
  assign w_s         = s_q;
  assign w_rd        = rd_q;
  assign w_reg_write = reg_write_q;
  assign w_valid     = valid_q;
  assign w_load_err  = load_err_q;

`ifdef RETIRE_COUNTER_EN
  logic [31:0] retired_q, retired_d;

  // Count valid instructions on real capture edges only; wraps naturally
  always_comb begin
    retired_d = retired_q;
    if (capture && m_valid) retired_d = retired_q + 32'd1;
  end

  // Retire counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign w_retired = retired_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, m_valid, m_reg_write;
  logic [31:0] m_alu_result, m_rdata, m_pc_plus4;
  logic [4:0]  m_rd;
  logic [1:0]  m_result_src;
  logic [2:0]  m_funct3;
  logic [31:0] w_input0, w_input1, w_input2;
  logic [1:0]  w_s;
  logic [4:0]  w_rd;
  logic        w_reg_write, w_valid, w_load_err;
`ifdef RETIRE_COUNTER_EN
  logic [31:0] w_retired;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RDATA = 32'h80FF_1234;

  mem_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_alu_result (m_alu_result),
    .m_rdata      (m_rdata),
    .m_pc_plus4   (m_pc_plus4),
    .m_rd         (m_rd),
    .m_reg_write  (m_reg_write),
    .m_result_src (m_result_src),
    .m_funct3     (m_funct3),
    .w_input0     (w_input0),
    .w_input1     (w_input1),
    .w_input2     (w_input2),
    .w_s          (w_s),
    .w_rd         (w_rd),
    .w_reg_write  (w_reg_write),
    .w_valid      (w_valid),
    .w_load_err   (w_load_err)
`ifdef RETIRE_COUNTER_EN
    ,
    .w_retired    (w_retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [1:0] es, input logic [4:0] erd,
                            input logic ewr, input logic ev, input logic eerr);
    check({tag, ".input0"}, w_input0, e0);
    check({tag, ".input1"}, w_input1, e1);
    check({tag, ".input2"}, w_input2, e2);
    check({tag, ".s"}, 32'(w_s), 32'(es));
    check({tag, ".rd"}, 32'(w_rd), 32'(erd));
    check({tag, ".reg_write"}, 32'(w_reg_write), 32'(ewr));
    check({tag, ".valid"}, 32'(w_valid), 32'(ev));
    check({tag, ".load_err"}, 32'(w_load_err), 32'(eerr));
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3);
    m_valid      = v;
    m_alu_result = alu;
    m_rdata      = RDATA;
    m_pc_plus4   = pc4;
    m_rd         = rd;
    m_reg_write  = rw;
    m_result_src = src;
    m_funct3     = f3;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b000);
    #2;
    expect_all("reset", 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef RETIRE_COUNTER_EN
    check("reset.retired", w_retired, 32'h0);
`endif
    rst_n = 1'b1;

    drive(1'b1, 32'h0000_1003, 32'h104, 5'd3, 1'b1, 2'b01, 3'b000);
    cycle();
    expect_all("lb", 32'h1003, 32'hFFFF_FF80, 32'h104, 2'd1, 5'd3, 1'b1, 1'b1, 1'b0);

    drive(1'b1, 32'h0000_2002, 32'h108, 5'd4, 1'b1, 2'b01, 3'b101);
    cycle();
    check("lhu.data", w_input1, 32'h0000_80FF);
    check("lhu.err", 32'(w_load_err), 32'd0);

    drive(1'b1, 32'h0000_3001, 32'h10C, 5'd5, 1'b1, 2'b01, 3'b010);
    cycle();
    expect_all("lw_mis", 32'h3001, RDATA, 32'h10C, 2'd1, 5'd5, 1'b1, 1'b1, 1'b1);

    drive(1'b1, 32'h0000_4002, 32'h110, 5'd6, 1'b1, 2'b01, 3'b001);
    cycle();
    check("lh_hi.data", w_input1, 32'hFFFF_80FF);
    check("lh_hi.err", 32'(w_load_err), 32'd0);

    drive(1'b1, 32'h0000_5001, 32'h114, 5'd6, 1'b1, 2'b01, 3'b100);
    cycle();
    check("lbu.data", w_input1, 32'h0000_0012);

    drive(1'b1, 32'h0000_5003, 32'h118, 5'd6, 1'b1, 2'b01, 3'b001);
    cycle();
    check("lh_mis.data", w_input1, RDATA);
    check("lh_mis.err", 32'(w_load_err), 32'd1);

    drive(1'b1, 32'h0000_5000, 32'h11C, 5'd6, 1'b1, 2'b01, 3'b110);
    cycle();
    check("unsup.data", w_input1, RDATA);
    check("unsup.err", 32'(w_load_err), 32'd1);

    drive(1'b1, 32'h0000_5000, 32'h120, 5'd6, 1'b1, 2'b00, 3'b110);
    cycle();
    check("unsup_alu.err", 32'(w_load_err), 32'd0);
    check("unsup_alu.s", 32'(w_s), 32'd0);

    drive(1'b1, 32'h0000_6000, 32'h124, 5'd8, 1'b1, 2'b01, 3'b010);
    cycle();
    check("lw.data", w_input1, RDATA);
    check("lw.err", 32'(w_load_err), 32'd0);

    drive(1'b1, 32'h0000_6000, 32'h128, 5'd0, 1'b1, 2'b00, 3'b010);
    cycle();
    check("rd0.reg_write", 32'(w_reg_write), 32'd0);
    check("rd0.valid", 32'(w_valid), 32'd1);

    drive(1'b1, 32'h0000_6000, 32'h12C, 5'd5, 1'b1, 2'b11, 3'b010);
    cycle();
    check("rsv.reg_write", 32'(w_reg_write), 32'd0);
    check("rsv.s", 32'(w_s), 32'd3);

    drive(1'b0, 32'h0000_6001, 32'h130, 5'd5, 1'b1, 2'b01, 3'b010);
    cycle();
    expect_all("invalid", 32'h6001, RDATA, 32'h130, 2'd1, 5'd5, 1'b0, 1'b0, 1'b0);

    drive(1'b1, 32'h0000_7000, 32'h200, 5'd7, 1'b1, 2'b00, 3'b010);
    cycle();
    expect_all("hold_a", 32'h7000, RDATA, 32'h200, 2'd0, 5'd7, 1'b1, 1'b1, 1'b0);

    stall = 1'b1;
    drive(1'b1, 32'h0000_8001, 32'h300, 5'd9, 1'b1, 2'b01, 3'b010);
    cycle();
    expect_all("stall", 32'h7000, RDATA, 32'h200, 2'd0, 5'd7, 1'b1, 1'b1, 1'b0);

    stall = 1'b0;
    flush = 1'b1;
    cycle();
    check("flush.valid", 32'(w_valid), 32'd0);
    check("flush.reg_write", 32'(w_reg_write), 32'd0);
    check("flush.load_err", 32'(w_load_err), 32'd0);

    flush = 1'b0;
    cycle();
    check("err_before_sf", 32'(w_load_err), 32'd1);
    stall = 1'b1;
    flush = 1'b1;
    cycle();
    check("stall_flush.valid", 32'(w_valid), 32'd0);
    check("stall_flush.reg_write", 32'(w_reg_write), 32'd0);
    check("stall_flush.load_err", 32'(w_load_err), 32'd0);
    stall = 1'b0;
    flush = 1'b0;

    #2;
    rst_n = 1'b0;
    #1;
    expect_all("async_rst", 32'h0, 32'h0, 32'h0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef RETIRE_COUNTER_EN
    check("async_rst.retired", w_retired, 32'h0);
`endif
    drive(1'b1, 32'h0000_1003, 32'h104, 5'd3, 1'b1, 2'b01, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    expect_all("post_rst", 32'h1003, 32'hFFFF_FF80, 32'h104, 2'd1, 5'd3, 1'b1, 1'b1, 1'b0);
    cycle();
    cycle();
    stall = 1'b1;
    cycle();
    stall = 1'b0;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("post_flush.valid", 32'(w_valid), 32'd0);
`ifdef RETIRE_COUNTER_EN
    check("retired.count", w_retired, 32'd3);
    stall = 1'b1;
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    cycle();
    check("retired.preload", w_retired, 32'hFFFF_FFFF);
    stall = 1'b0;
    cycle();
    check("retired.wrap", w_retired, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
